// File: rtl/bist_pkg.sv
// bist_pkg: shared state encoding and sizing helpers for the gray/Sobel BIST controller.
// Revision: 1.0
`default_nettype none

package bist_pkg;

  localparam int MAX_PIXEL_BITS = 24;
  localparam int PX_COUNT_DEF   = 1024;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } bist_state_e;

  function automatic int px_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int PX_CNT_W_DEF = px_cnt_width(PX_COUNT_DEF);

endpackage

`default_nettype wire

// File: rtl/bist_watchdog.sv
// bist_watchdog: loadable down-counter; expired flags the last enabled cycle of the window.
// Revision: 1.0
`default_nettype none

module bist_watchdog #(
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(TIMEOUT_CYC);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Expiry lands exactly TIMEOUT_CYC cycles after the load edge.
  assign expired = en && (cnt == W'(1));

endmodule

`default_nettype wire

// File: rtl/gray_sobel_bist_ctrl.sv
// gray_sobel_bist_ctrl: seeds LFSR, runs PX_COUNT pixels, checks SA signature. Optional BIST_SIG_CAPTURE_EN exposes sig_o.
// Revision: 1.0
`default_nettype none

module gray_sobel_bist_ctrl
  import bist_pkg::*;
#(
  parameter int PX_COUNT    = PX_COUNT_DEF,
  parameter int SIG_WIDTH   = MAX_PIXEL_BITS,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic                            clk_i,
  input  logic                            nreset_i,
  input  logic                            bist_start_i,
  input  logic                            abort_i,
  input  logic [1:0]                      select_i,
  input  logic [SIG_WIDTH-1:0]            seed_i,
  input  logic [SIG_WIDTH-1:0]            golden_i,
  input  logic                            px_rdy_i,
  input  logic                            sa_done_i,
  input  logic [SIG_WIDTH-1:0]            sa_sig_i,
  output logic [SIG_WIDTH-1:0]            lfsr_seed_o,
  output logic                            lfsr_seed_vld_o,
  output logic                            lfsr_en_o,
  output logic                            sobel_start_o,
  output logic [1:0]                      select_o,
  output logic                            sa_en_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            pass_o,
  output logic                            timeout_o,
  output logic [$clog2(PX_COUNT+1)-1:0]   px_cnt_o,
  output logic [SIG_WIDTH-1:0]            sig_o
);

  localparam int CW = px_cnt_width(PX_COUNT);

  bist_state_e          state;
  logic                 start_q;
  logic                 armed;
  logic [SIG_WIDTH-1:0] sig_q;
  logic [CW-1:0]        px_cnt_inc;
  logic                 start_rise;
  logic                 wd_load;
  logic                 wd_en;
  logic                 wd_expired;
  logic                 timeout_hit;

  // armed blocks a start level already high out of reset from counting as an edge.
  assign start_rise  = bist_start_i & ~start_q & armed;
  assign px_cnt_inc  = px_cnt_o + 1'b1;
  assign wd_en       = (state == RUN) || (state == DRAIN);
  assign wd_load     = (state == SEED) || ((state == RUN) && px_rdy_i);
  assign timeout_hit = wd_expired &&
                       (((state == RUN) && !px_rdy_i) || ((state == DRAIN) && !sa_done_i));

  bist_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk_i),
    .rst_n   (nreset_i),
    .load    (wd_load),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state           <= IDLE;
      start_q         <= 1'b0;
      armed           <= 1'b0;
      sig_q           <= '0;
      lfsr_seed_o     <= '0;
      lfsr_seed_vld_o <= 1'b0;
      lfsr_en_o       <= 1'b0;
      sobel_start_o   <= 1'b0;
      select_o        <= '0;
      sa_en_o         <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      pass_o          <= 1'b0;
      timeout_o       <= 1'b0;
      px_cnt_o        <= '0;
    end else begin
      start_q <= bist_start_i;
      armed   <= armed | ~bist_start_i;
      if (abort_i) begin
        state           <= IDLE;
        sig_q           <= '0;
        lfsr_seed_o     <= '0;
        lfsr_seed_vld_o <= 1'b0;
        lfsr_en_o       <= 1'b0;
        sobel_start_o   <= 1'b0;
        select_o        <= '0;
        sa_en_o         <= 1'b0;
        busy_o          <= 1'b0;
        done_o          <= 1'b0;
        pass_o          <= 1'b0;
        timeout_o       <= 1'b0;
        px_cnt_o        <= '0;
      end else if (timeout_hit) begin
        state         <= DONE;
        lfsr_en_o     <= 1'b0;
        sobel_start_o <= 1'b0;
        sa_en_o       <= 1'b0;
        select_o      <= '0;
        busy_o        <= 1'b0;
        done_o        <= 1'b1;
        pass_o        <= 1'b0;
        timeout_o     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start_rise) begin
              state           <= SEED;
              lfsr_seed_o     <= seed_i;
              lfsr_seed_vld_o <= 1'b1;
              select_o        <= select_i;
              busy_o          <= 1'b1;
            end
          end
          SEED: begin
            state           <= RUN;
            lfsr_seed_o     <= '0;
            lfsr_seed_vld_o <= 1'b0;
            px_cnt_o        <= '0;
            sig_q           <= '0;
            lfsr_en_o       <= 1'b1;
            sobel_start_o   <= 1'b1;
            sa_en_o         <= 1'b1;
          end
          RUN: begin
            if (px_rdy_i) begin
              px_cnt_o <= px_cnt_inc;
              if (px_cnt_inc == CW'(PX_COUNT)) begin
                state         <= DRAIN;
                lfsr_en_o     <= 1'b0;
                sobel_start_o <= 1'b0;
              end
            end
          end
          DRAIN: begin
            if (sa_done_i) begin
              state   <= CHECK;
              sig_q   <= sa_sig_i;
              sa_en_o <= 1'b0;
            end
          end
          CHECK: begin
            state    <= DONE;
            pass_o   <= (sig_q == golden_i);
            done_o   <= 1'b1;
            busy_o   <= 1'b0;
            select_o <= '0;
          end
          DONE: begin
            if (!bist_start_i) begin
              state     <= IDLE;
              done_o    <= 1'b0;
              pass_o    <= 1'b0;
              timeout_o <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef BIST_SIG_CAPTURE_EN
  assign sig_o = sig_q;
`else
  assign sig_o = '0;
`endif

endmodule

`default_nettype wire
